// File: rtl/alu_pkg.sv
// Shared types and constants for the signed 8-bit arithmetic unit.
// Opcode encoding, operand/result widths and a sign-extension helper.
package alu_pkg;

    localparam int OPW  = 8;
    localparam int RESW = 16;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } alu_op_t;

    // Widen a two's-complement operand to the result width.
    function automatic logic signed [RESW-1:0] sext(input logic [OPW-1:0] v);
        return {{(RESW-OPW){v[OPW-1]}}, v};
    endfunction

endpackage

// File: rtl/alu_sdiv.sv
// Combinational signed 8/8 divider: restoring array on magnitudes, then sign fix.
// Quotient truncates toward zero; divide by zero yields zero.
module alu_sdiv
    import alu_pkg::*;
(
    input  logic [OPW-1:0]  dividend,
    input  logic [OPW-1:0]  divisor,
    output logic [RESW-1:0] quotient
);

    logic [OPW-1:0] a_mag_s;
    logic [OPW-1:0] b_mag_s;
    logic [OPW-1:0] a_shift_s;
    logic [OPW:0]   rem_s;
    logic [OPW-1:0] q_mag_s;
    logic           neg_s;

    // Magnitudes of both operands; -128 maps cleanly to unsigned 128.
    always_comb begin
        if (dividend[OPW-1]) begin
            a_mag_s = 8'd0 - dividend;
        end else begin
            a_mag_s = dividend;
        end
        if (divisor[OPW-1]) begin
            b_mag_s = 8'd0 - divisor;
        end else begin
            b_mag_s = divisor;
        end
        neg_s = dividend[OPW-1] ^ divisor[OPW-1];
    end

    // Restoring division, one quotient bit per row, MSB first.
    always_comb begin
        rem_s     = 9'd0;
        q_mag_s   = 8'd0;
        a_shift_s = a_mag_s;
        for (int i = 0; i < OPW; i++) begin
            rem_s     = {rem_s[OPW-1:0], a_shift_s[OPW-1]};
            a_shift_s = {a_shift_s[OPW-2:0], 1'b0};
            if (rem_s >= {1'b0, b_mag_s}) begin
                rem_s   = rem_s - {1'b0, b_mag_s};
                q_mag_s = {q_mag_s[OPW-2:0], 1'b1};
            end else begin
                q_mag_s = {q_mag_s[OPW-2:0], 1'b0};
            end
        end
    end

    // Apply the quotient sign; a zero divisor forces zero.
    always_comb begin
        if (divisor == 8'd0) begin
            quotient = 16'h0000;
        end else if (neg_s) begin
            quotient = 16'h0000 - {8'd0, q_mag_s};
        end else begin
            quotient = {8'd0, q_mag_s};
        end
    end

endmodule

// File: rtl/alu_design.sv
// Signed 8-bit add/sub/mul/div with a sign-extended 16-bit registered result.
// One-cycle latency; asynchronous active-low reset clears the result.
module alu_design
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [OPW-1:0]  num1,
    input  logic [OPW-1:0]  num2,
    input  logic [1:0]      sel,
    output logic [RESW-1:0] result
);

    logic signed [RESW-1:0] a_ext_s;
    logic signed [RESW-1:0] b_ext_s;
    logic signed [RESW-1:0] prod_s;
    logic [RESW-1:0]        quot_s;
    logic [RESW-1:0]        next_s;
    logic [RESW-1:0]        result_r;
    alu_op_t                op_s;

    alu_sdiv u_sdiv (
        .dividend (num1),
        .divisor  (num2),
        .quotient (quot_s)
    );

    // Operand widening and the signed product (fits 16 bits for 8x8 inputs).
    always_comb begin
        a_ext_s = sext(num1);
        b_ext_s = sext(num2);
        prod_s  = a_ext_s * b_ext_s;
        op_s    = alu_op_t'(sel);
    end

    // Select the operation result to be registered.
    always_comb begin
        next_s = 16'h0000;
        case (op_s)
            OP_ADD:  next_s = a_ext_s + b_ext_s;
            OP_SUB:  next_s = a_ext_s - b_ext_s;
            OP_MUL:  next_s = prod_s;
            OP_DIV:  next_s = quot_s;
            default: next_s = 16'h0000;
        endcase
    end

    // Result register; reset drops any pending computation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_r <= 16'h0000;
        end else begin
            result_r <= next_s;
        end
    end

    assign result = result_r;

endmodule

// File: tb/tb_alu_design.sv
// Directed, table-driven bench for alu_design plus reset and back-to-back sequences.
module tb_alu_design;

    logic        clk;
    logic        reset;
    logic [7:0]  num1;
    logic [7:0]  num2;
    logic [1:0]  sel;
    logic [15:0] result;

    int n_vec;
    int n_bad;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [1:0]  op;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[18];

    alu_design dut (
        .clk    (clk),
        .reset  (reset),
        .num1   (num1),
        .num2   (num2),
        .sel    (sel),
        .result (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: result=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic apply(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        @(negedge clk);
        num1 = a;
        num2 = b;
        sel  = op;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        vecs[0]  = '{8'h80, 8'h01, 2'd0, 16'hFF81};
        vecs[1]  = '{8'h7F, 8'h7F, 2'd0, 16'h00FE};
        vecs[2]  = '{8'h80, 8'h01, 2'd1, 16'hFF7F};
        vecs[3]  = '{8'h7F, 8'h80, 2'd1, 16'h00FF};
        vecs[4]  = '{8'h80, 8'h7F, 2'd1, 16'hFF01};
        vecs[5]  = '{8'h80, 8'h01, 2'd2, 16'hFF80};
        vecs[6]  = '{8'h80, 8'h80, 2'd2, 16'h4000};
        vecs[7]  = '{8'hFF, 8'hFF, 2'd2, 16'h0001};
        vecs[8]  = '{8'h7F, 8'h80, 2'd2, 16'hC080};
        vecs[9]  = '{8'h80, 8'h02, 2'd3, 16'hFFC0};
        vecs[10] = '{8'hF9, 8'h02, 2'd3, 16'hFFFD};
        vecs[11] = '{8'h80, 8'hFF, 2'd3, 16'h0080};
        vecs[12] = '{8'h05, 8'h00, 2'd3, 16'h0000};
        vecs[13] = '{8'h7F, 8'h03, 2'd3, 16'h002A};
        vecs[14] = '{8'h64, 8'hF9, 2'd3, 16'hFFF2};
        vecs[15] = '{8'h07, 8'hF9, 2'd3, 16'hFFFF};
        vecs[16] = '{8'h01, 8'h7F, 2'd3, 16'h0000};
        vecs[17] = '{8'h0C, 8'h0C, 2'd3, 16'h0001};

        // Reset held low with arbitrary inputs across edges.
        reset = 1'b0;
        num1  = 8'h7F;
        num2  = 8'h7F;
        sel   = 2'd2;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", result, 16'h0000);

        // Release: first edge with reset high loads the current computation.
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release", result, 16'h3F01);

        for (int i = 0; i < 18; i++) begin
            apply(vecs[i].a, vecs[i].b, vecs[i].op);
            check($sformatf("vec%0d", i), result, vecs[i].exp);
        end

        // Result holds between edges even when inputs change.
        num1 = 8'h10;
        num2 = 8'h10;
        sel  = 2'd0;
        #3;
        check("hold_between_edges", result, 16'h0001);

        // Back-to-back opcodes with fixed operands 20 and -5.
        apply(8'h14, 8'hFB, 2'd0);
        check("b2b_add", result, 16'h000F);
        apply(8'h14, 8'hFB, 2'd1);
        check("b2b_sub", result, 16'h0019);

        // Asynchronous reset mid-sequence, no clock edge needed.
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", result, 16'h0000);
        apply(8'h14, 8'hFB, 2'd2);
        check("reset_low_edge", result, 16'h0000);

        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("b2b_mul_after_release", result, 16'hFF9C);
        apply(8'h14, 8'hFB, 2'd3);
        check("b2b_div", result, 16'hFFFC);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
